// File: rtl/sig_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sig_ctrl
// Brief    : Three-key EDIT/RUN controller for a waveform generator. Keys are
//            synchronized, conditioned and edge-detected into press pulses that
//            edit shadow registers; outputs load from the shadows on EDIT->RUN.
//            Optional debouncer: define SIG_CTRL_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sig_ctrl #(
    parameter int CLK_HZ = 50000000,
    parameter int DEB_MS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_ok,
    output logic [1:0] cnt_sig,
    output logic [1:0] cnt_amp,
    output logic [1:0] cnt_fre,
    output logic [1:0] cnt_phase,
    output logic       confirm,
    output logic [1:0] sel,
    output logic       run
);

    localparam int NKEY = 3;

    // Field order inside the packed parameter sets: [0] sig, [1] amp, [2] fre, [3] phase
    localparam logic [3:0][1:0] PAR_RST = {2'd0, 2'd0, 2'd1, 2'd0};

    generate
        if (CLK_HZ < 1000 || DEB_MS < 1) begin : g_cfg_err
            $error("sig_ctrl: CLK_HZ must be >= 1000 and DEB_MS >= 1");
        end
    endgenerate

    logic [NKEY-1:0] keys_raw;
    logic [NKEY-1:0] key_pulse;

    assign keys_raw = {key_ok, key_mode, key_inc};

    generate
        for (genvar i = 0; i < NKEY; i++) begin : g_key
            logic sync1, sync2, deb, deb_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1 <= 1'b1;
                    sync2 <= 1'b1;
                end else begin
                    sync1 <= keys_raw[i];
                    sync2 <= sync1;
                end
            end

`ifdef SIG_CTRL_DEBOUNCE_EN
            localparam int DEB_CNT = CLK_HZ / 1000 * DEB_MS;
            localparam int CW      = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT + 1);
            logic [CW-1:0] cnt;

            // Accept the new level one edge after DEB_CNT differing samples, which
            // keeps the latency exactly DEB_CNT beyond the plain one-stage path.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                    deb <= 1'b1;
                end else if (sync2 == deb) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_CNT)) begin
                    cnt <= '0;
                    deb <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
`else
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) deb <= 1'b1;
                else        deb <= sync2;
            end
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) deb_d <= 1'b1;
                else        deb_d <= deb;
            end

            assign key_pulse[i] = deb_d & ~deb;
        end
    endgenerate

    typedef enum logic {EDIT = 1'b0, RUN = 1'b1} state_t;

    state_t          state, state_nx;
    logic [1:0]      sel_q, sel_nx;
    logic [3:0][1:0] sh, sh_nx;
    logic [3:0][1:0] par, par_nx;

    logic inc_p, mode_p, ok_p;
    assign inc_p  = key_pulse[0];
    assign mode_p = key_pulse[1];
    assign ok_p   = key_pulse[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EDIT;
            sel_q <= 2'd0;
            sh    <= PAR_RST;
            par   <= PAR_RST;
        end else begin
            state <= state_nx;
            sel_q <= sel_nx;
            sh    <= sh_nx;
            par   <= par_nx;
        end
    end

    // Priority ok > mode > inc; only EDIT accepts mode/inc.
    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        sh_nx    = sh;
        par_nx   = par;
        case (state)
            EDIT: begin
                if (ok_p) begin
                    par_nx   = sh;
                    state_nx = RUN;
                end else if (mode_p) begin
                    sel_nx = sel_q + 2'd1;
                end else if (inc_p) begin
                    sh_nx[sel_q] = sh[sel_q] + 2'd1;
                end
            end
            RUN: begin
                if (ok_p) state_nx = EDIT;
            end
            default: state_nx = EDIT;
        endcase
    end

    assign cnt_sig   = par[0];
    assign cnt_amp   = par[1];
    assign cnt_fre   = par[2];
    assign cnt_phase = par[3];
    assign sel       = sel_q;
    assign confirm   = (state == RUN);
    assign run       = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_sig_ctrl.sv
`default_nettype none
// Self-checking bench for sig_ctrl: directed and random key presses compared
// against a press-level behavioural model of the controller.
module tb_sig_ctrl;

`ifdef SIG_CTRL_DEBOUNCE_EN
    localparam int LAT = 3 + 8;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode, key_inc, key_ok;
    logic [1:0] cnt_sig, cnt_amp, cnt_fre, cnt_phase, sel;
    logic       confirm, run;

    always #5 clk = ~clk;

    sig_ctrl #(.CLK_HZ(1000), .DEB_MS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_ok    (key_ok),
        .cnt_sig   (cnt_sig),
        .cnt_amp   (cnt_amp),
        .cnt_fre   (cnt_fre),
        .cnt_phase (cnt_phase),
        .confirm   (confirm),
        .sel       (sel),
        .run       (run)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 sig, 1 amp, 2 fre, 3 phase
    bit m_run;
    int m_sel;
    int m_sh[4];
    int m_cnt[4];

    logic [11:0] obs;
    assign obs = {run, confirm, sel, cnt_sig, cnt_amp, cnt_fre, cnt_phase};

    function automatic logic [11:0] model_vec();
        return {m_run, m_run, 2'(m_sel), 2'(m_cnt[0]), 2'(m_cnt[1]),
                2'(m_cnt[2]), 2'(m_cnt[3])};
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_sel = 0;
        m_sh  = '{0, 1, 0, 0};
        m_cnt = '{0, 1, 0, 0};
    endtask

    task automatic model_apply(input bit ok, input bit mode, input bit inc);
        if (ok) begin
            if (!m_run) begin
                m_cnt = m_sh;
                m_run = 1'b1;
            end else begin
                m_run = 1'b0;
            end
        end else if (!m_run) begin
            if (mode)     m_sel = (m_sel + 1) % 4;
            else if (inc) m_sh[m_sel] = (m_sh[m_sel] + 1) % 4;
        end
    endtask

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Caller has already driven the keys low on a negedge; the next posedge is edge k.
    task automatic follow_press(input string tag, input bit ok, input bit mode,
                                input bit inc, input int extra);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check({tag, "_pre"}, obs, model_vec());
        @(posedge clk);
        @(negedge clk);
        model_apply(ok, mode, inc);
        check({tag, "_post"}, obs, model_vec());
        repeat (extra) @(negedge clk);
        key_ok   = 1'b1;
        key_mode = 1'b1;
        key_inc  = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check({tag, "_rel"}, obs, model_vec());
    endtask

    task automatic press(input string tag, input bit ok, input bit mode,
                         input bit inc, input int extra);
        @(negedge clk);
        key_ok   = ~ok;
        key_mode = ~mode;
        key_inc  = ~inc;
        follow_press(tag, ok, mode, inc, extra);
    endtask

    initial begin
        key_mode = 1'b1;
        key_inc  = 1'b1;
        key_ok   = 1'b1;
        rst_n    = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check("reset", obs, model_vec());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: outputs must stay at their reset values
        for (int i = 0; i < 4; i++) begin
            repeat (15) @(negedge clk);
            check("idle", obs, 12'b0_0_00_00_01_00_00);
        end

        // mode x2, inc x3, ok
        press("m1", 0, 1, 0, 0);
        press("m2", 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) press("i", 0, 0, 1, 1);
        press("ok1", 1, 0, 0, 0);
        check("fre_run", obs, {1'b1, 1'b1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0});

        // Back to EDIT, reselect sig, inc x5 -> sig wraps to 1
        press("ok2", 1, 0, 0, 0);
        check("hold_edit", obs, {1'b0, 1'b0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0});
        press("m3", 0, 1, 0, 0);
        press("m4", 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) press("i5", 0, 0, 1, 0);
        press("ok3", 1, 0, 0, 0);
        check("sig_wrap", obs, {1'b1, 1'b1, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0});

        // RUN ignores mode and inc
        press("run_m", 0, 1, 0, 0);
        press("run_i", 0, 0, 1, 0);
        press("ok4", 1, 0, 0, 0);
        check("run_ign", obs, {1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0});

        // ok and inc together in EDIT: RUN entered, shadow untouched
        press("ok_inc", 1, 0, 1, 0);
        press("ok5", 1, 0, 0, 0);
        press("ok6", 1, 0, 0, 0);
        check("ok_inc_sh", obs, {1'b1, 1'b1, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0});
        press("ok7", 1, 0, 0, 0);

        // Long hold gives a single pulse
        press("hold", 0, 1, 0, 100);

`ifdef SIG_CTRL_DEBOUNCE_EN
        // Short glitch must be filtered
        @(negedge clk);
        key_mode = 1'b0;
        repeat (5) @(negedge clk);
        key_mode = 1'b1;
        repeat (25) @(negedge clk);
        check("glitch", obs, model_vec());
`endif

        // Random key combinations, including simultaneous presses
        for (int n = 0; n < 40; n++) begin
            int c;
            c = $urandom_range(1, 7);
            press("rnd", c[2], c[1], c[0], $urandom_range(0, 5));
        end

        // Reset mid-RUN with mode held through deassertion
        if (!m_run) press("ok_pre_rst", 1, 0, 0, 0);
        @(negedge clk);
        key_mode = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_async", obs, 12'b0_0_00_00_01_00_00);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        follow_press("held_rst", 0, 1, 0, 0);
        check("held_rst_sel", obs, 12'b0_0_01_00_01_00_00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
